// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the load/store sequencer.
package lsu_pkg;

  // Highest valid byte address of the attached data memory.
  localparam logic [31:0] MEM_END_DEFAULT = 32'h0001_FFFF;

  // Access size as encoded on the request interface.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } lsu_size_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

  // Number of bytes touched by an access; the illegal size maps to 4 so the
  // range arithmetic stays well defined even though that request errors out.
  function automatic logic [2:0] size_to_nbytes(input lsu_size_t size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign- or zero-extends assembled load data to full width.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] assembly,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  logic      sign_b;
  logic      sign_h;
  lsu_size_t size_e;

  assign size_e = lsu_size_t'(size);
  assign sign_b = assembly[7] & ~is_unsigned;
  assign sign_h = assembly[15] & ~is_unsigned;

  // Replicate the sign bit of the loaded byte/half, or zeros for unsigned loads.
  always_comb begin
    data = assembly;
    case (size_e)
      SZ_B:    data = {{(DATA_WIDTH-8){sign_b}}, assembly[7:0]};
      SZ_H:    data = {{(DATA_WIDTH-16){sign_h}}, assembly[15:0]};
      default: data = assembly;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: turns one core load/store request into aligned word or
// sequential byte accesses on the data memory and returns a single response.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] MEM_END    = DATA_WIDTH'(MEM_END_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  lsu_state_t            state;

  // Captured request, held stable for the whole access.
  logic                  cap_we;
  logic [1:0]            cap_size;
  logic                  cap_unsigned;
  logic [DATA_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  word_mode;
  logic [1:0]            last_count;

  // Byte index within a byte-mode access and the load assembly register.
  logic [1:0]            count;
  logic [1:0]            next_count;
  logic [DATA_WIDTH-1:0] assembly;
  logic [DATA_WIDTH-1:0] next_assembly;
  logic [DATA_WIDTH-1:0] ext_data;

  // Registered outputs.
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  mem_we_q;
  logic                  mem_byte_op_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wd_q;

  // Decode of the incoming request, only meaningful in IDLE.
  lsu_size_t             req_size;
  logic [2:0]            req_nbytes;
  logic [DATA_WIDTH:0]   span_end;
  logic                  req_err;
  logic                  req_word;

  assign req_size   = lsu_size_t'(req_size_i);
  assign req_nbytes = size_to_nbytes(req_size);

  // One extra bit catches accesses whose last byte wraps past the address space.
  assign span_end = {1'b0, req_addr_i}
                  + {{(DATA_WIDTH-2){1'b0}}, req_nbytes - 3'd1};

  assign req_err  = (req_size == SZ_BAD)
                  || span_end[DATA_WIDTH]
                  || (span_end[DATA_WIDTH-1:0] > MEM_END);

  assign req_word = (req_size == SZ_W) && (req_addr_i[1:0] == 2'b00);

  assign next_count = count + 2'd1;

  // Merge the data the memory returns this cycle into the assembly register.
  always_comb begin
    next_assembly = assembly;
    if (state == ACCESS) begin
      if (word_mode) begin
        next_assembly = mem_rd_i;
      end else begin
        next_assembly[BYTE_WIDTH*count +: BYTE_WIDTH] = mem_rd_i[BYTE_WIDTH-1:0];
      end
    end
  end

  lsu_load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .assembly    (next_assembly),
    .size        (cap_size),
    .is_unsigned (cap_unsigned),
    .data        (ext_data)
  );

  // Sequencer FSM: captures the request, steps the memory cycles and
  // produces the registered memory-side and response-side outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cap_we        <= 1'b0;
      cap_size      <= 2'b00;
      cap_unsigned  <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      word_mode     <= 1'b0;
      last_count    <= 2'd0;
      count         <= 2'd0;
      assembly      <= '0;
      ready_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_byte_op_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wd_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            cap_we       <= req_we_i;
            cap_size     <= req_size_i;
            cap_unsigned <= req_unsigned_i;
            cap_addr     <= req_addr_i;
            cap_wdata    <= req_wdata_i;
            word_mode    <= req_word;
            last_count   <= 2'(req_nbytes - 3'd1);
            count        <= 2'd0;
            assembly     <= '0;
            ready_q      <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state         <= ACCESS;
              mem_we_q      <= req_we_i;
              mem_byte_op_q <= ~req_word;
              mem_addr_q    <= req_addr_i;
              mem_wd_q      <= req_word ? req_wdata_i
                                        : DATA_WIDTH'(req_wdata_i[BYTE_WIDTH-1:0]);
            end
          end
        end

        ACCESS: begin
          assembly <= next_assembly;
          if (word_mode || (count == last_count)) begin
            state         <= RESP;
            mem_we_q      <= 1'b0;
            mem_byte_op_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wd_q      <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= cap_we ? '0 : ext_data;
          end else begin
            count      <= next_count;
            mem_addr_q <= cap_addr + DATA_WIDTH'(next_count);
            mem_wd_q   <= DATA_WIDTH'(cap_wdata[BYTE_WIDTH*next_count +: BYTE_WIDTH]);
          end
        end

        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  // The memory writes on the falling edge, so reset must block a write in
  // the very cycle it is asserted, not one edge later.
  assign mem_we_o      = mem_we_q & rst_ni;
  assign mem_byte_op_o = mem_byte_op_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wd_o      = mem_wd_q;

endmodule
